// File: rtl/seq_bla_subtractor_pkg.sv
// Shared definitions for the digit-serial borrow-lookahead subtractor:
// FSM state encoding and the digit width.
package sub_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_bla_subtractor_bla4_slice.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - bi, bo = borrow out.
// Lookahead is fully flattened; no borrow ripples between bit positions.
module bla4_slice
  import sub_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo
);

  logic [DIGIT_W-1:0] p;
  logic [DIGIT_W-1:0] g;
  logic               b1, b2, b3;

  // p: borrow passes through (bits equal); g: borrow created (x=0, y=1)
  assign p = ~(x ^ y);
  assign g = ~x & y;

  assign b1 = g[0] | (p[0] & bi);
  assign b2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign b3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & bi);
  assign bo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = x ^ y ^ {b3, b2, b1, bi};

endmodule

// File: rtl/seq_bla_subtractor.sv
// Digit-serial subtractor diff = a - b - bin, one 4-bit digit per clock, LSB first.
// Optional signed-overflow output ovf is built when SUB_OVERFLOW_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand set
// RUN   | one digit per edge through the shared slice, cnt = digit index
// DONE  | out_valid=1, result held until out_ready
module seq_bla_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t             state_q, state_nx;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, diff_q;
  logic               brw_q, bout_q;
  logic [DIGIT_W-1:0] sl_x, sl_y, sl_d;
  logic               sl_bo;
  logic               last;

  assign last = (cnt_q == CW'(NDIG - 1));
  assign sl_x = a_q[cnt_q*DIGIT_W +: DIGIT_W];
  assign sl_y = b_q[cnt_q*DIGIT_W +: DIGIT_W];

  bla4_slice u_slice (
    .x  (sl_x),
    .y  (sl_y),
    .bi (brw_q),
    .d  (sl_d),
    .bo (sl_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            brw_q  <= bin;
            cnt_q  <= '0;
            diff_q <= '0;
          end
        end
        S_RUN: begin
          diff_q[cnt_q*DIGIT_W +: DIGIT_W] <= sl_d;
          brw_q <= sl_bo;
          cnt_q <= cnt_q + CW'(1);
          if (last) bout_q <= sl_bo;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic ovf_q;

  // Final digit's d[3] is the result MSB; operands of differing sign must keep a's sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sl_d[DIGIT_W-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_seq_bla_subtractor.sv
// Self-checking bench for seq_bla_subtractor (WIDTH=16): directed vectors plus
// random operations against an integer-arithmetic reference model.
module tb_seq_bla_subtractor;

  localparam int WIDTH = 16;
  localparam int NDIG  = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  seq_bla_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned for diff/bout, signed for ovf.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                       output logic [15:0] ed, output logic eb, output logic eo);
    int ru, rs;
    ru = int'(ta) - int'(tb) - int'(tbin);
    ed = ru[15:0];
    eb = (ru < 0);
    rs = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    eo = (rs > 32767) || (rs < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                       input int stall, input logic chk_ovf, input logic exp_ovf);
    logic [15:0] ed;
    logic        eb, eo;
    int          n;
    model(ta, tb, tbin, ed, eb, eo);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_op", in_ready, 1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      chk("in_ready_busy", in_ready, 0);
      tick();
      n++;
    end
    chk("latency", n, NDIG);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    if (chk_ovf) chk("model_ovf", eo, exp_ovf);
`ifdef SUB_OVERFLOW_EN
    chk("ovf", ovf, eo);
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_diff", diff, ed);
      chk("stall_bout", bout, eb);
`ifdef SUB_OVERFLOW_EN
      chk("stall_ovf", ovf, eo);
`endif
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("retain_diff", diff, ed);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", ovf, 0);
`endif

    do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0004, 1'b1, 0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b1, 1'b1);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b1, 1'b1);
    // Stall 5 cycles in DONE with competing operands on the input
    do_op(16'h0000, 16'h0001, 1'b0, 5, 1'b0, 1'b0);

    // Reset on the second RUN edge; previous op left bout=1
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    do_op(16'h0003, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    // Reset and in_valid together: nothing is accepted
    a = 16'h4321; b = 16'h0001; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("rst_vs_valid_idle", in_ready, 1);
    chk("rst_vs_valid_no_result", out_valid, 0);
    chk("rst_vs_valid_diff", diff, 0);

    for (int k = 0; k < 40; k++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
